aes_decrypt_core: RTL
=====================

Name: aes_decrypt_core

Overview:
- Iterative AES-128 inverse cipher. Takes a 128-bit ciphertext and the pre-expanded 11-round-key schedule, and returns the plaintext.
- Executes one inverse round per clock through a valid/ready handshake on both sides.
- Decrypt-side counterpart of the encryption round datapath (subbytes/shiftrows/mixcolumns/addroundkey chain).
- Shares the 1408-bit expanded-key bus format with the encryption path.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is legal.
- KEY_W, 128*(NR+1) = 1408, width of the expanded-key bus.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- key  input  KEY_W  expanded schedule; round key r (0..10) = key[KEY_W-1-128*r -: 128], so rk0 is in the MSBs; must be held stable from input acceptance until out_valid
- in_data  input  128  ciphertext, byte 0 in bits [127:120], column-major state
- in_valid  input  1  in_data valid
- in_ready  output  1  core idle and able to accept
- out  output  128  plaintext, same byte order as in_data
- out_valid  output  1  out holds a finished result
- out_ready  input  1  consumer accepts out
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, rnd=0, st=0, out=0, out_valid=0, busy=0. in_ready=0 while rst==0.
  - A reset mid-operation discards the block in flight. No output is produced for it.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE) and rst==1.
  - out_valid = (state==DONE).
- IDLE:
  - Acceptance: in_valid & in_ready at an edge.
  - On acceptance: st <= in_data ^ rk10, rnd <= 9, go to RUN.
- RUN, rnd != 0: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[rnd]), then rnd <= rnd-1.
- RUN, rnd == 0:
  - out <= InvSubBytes(InvShiftRows(st)) ^ rk0.
  - No InvMixColumns in this final round.
  - Go to DONE.
- DONE:
  - out and out_valid are held until out_valid & out_ready at an edge, then go to IDLE.
  - out keeps its last value after the transfer; only out_valid drops.
- Latency:
  - The acceptance edge is E0; out_valid is first high after edge E10.
  - The earliest next acceptance is the edge after the output transfer.
  - Throughput: 1 block per 12 cycles when out_ready is tied high.
- Handshake edge cases:
  - in_valid is ignored outside IDLE, so a held in_valid is not double-accepted.
  - out_ready outside DONE has no effect.
- Arithmetic:
  - InvMixColumns uses GF(2^8) with polynomial 0x11B and coefficients {0e,0b,0d,09}.
  - xtime is a shift left with a conditional ^0x1B.
- rnd is 4 bits and never wraps below 0.

Optional Feature:
- Macro: AES_DEC_UNROLL2_EN.
- When defined, two inverse rounds are applied per RUN cycle: rnd steps 9→7→5→3→1.
- At rnd==1 the RUN cycle computes round 1 with InvMixColumns, then the final rk0 round without it, writes out, and goes to DONE.
- out_valid is first high after edge E5 instead of E10.
- Ports, reset values and handshake are unchanged.
- When undefined, one round per cycle as above.

Decomposition:
- Package aes_dec_pkg holds:
  - the 256-entry inverse S-box constant;
  - NR and the round-key slice function rk(key, r);
  - the state enum {IDLE, RUN, DONE};
  - the gf_mul2/gf_mul constant functions.
- One combinational sub-module, aes_inv_round:
  - inputs: 128-bit state, 128-bit round key, final flag;
  - output: 128-bit next state;
  - operations: InvShiftRows, then InvSubBytes, then AddRoundKey, then InvMixColumns unless final.
- Instantiated once, or twice chained under AES_DEC_UNROLL2_EN.

Test Plan:
- FIPS-197 C.1 vector:
  - stimulus: key schedule from 000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a;
  - required: out=00112233445566778899aabbccddeeff;
  - required: out_valid rises exactly 10 cycles after acceptance (5 with AES_DEC_UNROLL2_EN).
- FIPS-197 Appendix B vector:
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32;
  - required: out=3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - stimulus: hold out_ready=0 for 20 cycles after out_valid, with in_valid held high and new data throughout;
  - required: out stable, in_ready=0, no second acceptance;
  - required: after out_ready=1 for one edge, IDLE and the next block is accepted on the following edge.
- Reset mid-operation:
  - stimulus: drive rst=0 for one edge at rnd==5;
  - required: next cycle out_valid=0, busy=0, out=0, in_ready=1 once rst=1;
  - required: a subsequent C.1 run still passes.
- Back-to-back:
  - stimulus: 8 random ciphertexts encrypted by the team's encrypt path, out_ready tied 1;
  - required: each decrypts to its original plaintext, in order, at 12-cycle spacing.
- Round-trip sweep: 1000 random key/plaintext pairs through encrypt then this core → identity.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_dec_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned KEY_W = 128 * (NR + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Round key r of the expanded schedule; rk0 sits in the MSBs.
    function automatic logic [127:0] rk(input logic [KEY_W-1:0] key, input logic [3:0] r);
        return key[KEY_W - 1 - 128 * int'(r) -: 128];
    endfunction

    // xtime: multiply by x modulo 0x11B.
    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-add; folds to XOR trees for constant b.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_mul2(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rkey,
    input  logic         last,
    output logic [127:0] nxt
);

    logic [7:0] a [16];
    logic [7:0] m [16];

    // Byte 4*c+r is row r of column c; row r rotates right by r on the way in.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[4*c+r] = INV_SBOX[st[8*(15 - (4*((c + 4 - r) % 4) + r)) +: 8]]
                           ^ rkey[8*(15 - (4*c + r)) +: 8];
            end
        end
    end

    // InvMixColumns with the {0e,0b,0d,09} circulant.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            m[4*c+0] = gf_mul(a[4*c], 8'h0e) ^ gf_mul(a[4*c+1], 8'h0b)
                     ^ gf_mul(a[4*c+2], 8'h0d) ^ gf_mul(a[4*c+3], 8'h09);
            m[4*c+1] = gf_mul(a[4*c], 8'h09) ^ gf_mul(a[4*c+1], 8'h0e)
                     ^ gf_mul(a[4*c+2], 8'h0b) ^ gf_mul(a[4*c+3], 8'h0d);
            m[4*c+2] = gf_mul(a[4*c], 8'h0d) ^ gf_mul(a[4*c+1], 8'h09)
                     ^ gf_mul(a[4*c+2], 8'h0e) ^ gf_mul(a[4*c+3], 8'h0b);
            m[4*c+3] = gf_mul(a[4*c], 8'h0b) ^ gf_mul(a[4*c+1], 8'h0d)
                     ^ gf_mul(a[4*c+2], 8'h09) ^ gf_mul(a[4*c+3], 8'h0e);
        end
    end

    // Final round skips the column mix.
    always_comb begin
        nxt = '0;
        for (int i = 0; i < 16; i++) begin
            nxt[8*(15 - i) +: 8] = last ? a[i] : m[i];
        end
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher with valid/ready on both sides.
// Optional AES_DEC_UNROLL2_EN: two inverse rounds per RUN cycle (rnd 9,7,5,3,1).
module aes_decrypt_core
    import aes_dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   rnd;
    logic [3:0]   rnd_nxt;
    logic [127:0] st;
    logic [127:0] st_nxt;
    logic [127:0] out_nxt;
    logic [127:0] r0;

`ifdef AES_DEC_UNROLL2_EN
    logic [127:0] r1;
    logic [3:0]   rnd_lo;

    // Second round of the pair uses the next-lower key; clamp keeps the select in range in IDLE.
    assign rnd_lo = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;

    aes_inv_round u_round_hi (
        .st   (st),
        .rkey (rk(key, rnd)),
        .last (1'b0),
        .nxt  (r0)
    );

    aes_inv_round u_round_lo (
        .st   (r0),
        .rkey (rk(key, rnd_lo)),
        .last (rnd == 4'd1),
        .nxt  (r1)
    );
`else
    aes_inv_round u_round (
        .st   (st),
        .rkey (rk(key, rnd)),
        .last (rnd == 4'd0),
        .nxt  (r0)
    );
`endif

    assign in_ready  = rst && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // State, round counter, round state and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rnd   <= 4'd0;
            st    <= '0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            st    <= st_nxt;
            out   <= out_nxt;
        end
    end

    // Next-state and datapath selection.
    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd;
        st_nxt    = st;
        out_nxt   = out;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    st_nxt    = in_data ^ rk(key, 4'(NR));
                    rnd_nxt   = 4'(NR - 1);
                    state_nxt = RUN;
                end
            end
            RUN: begin
`ifdef AES_DEC_UNROLL2_EN
                if (rnd == 4'd1) begin
                    out_nxt   = r1;
                    state_nxt = DONE;
                end else begin
                    st_nxt  = r1;
                    rnd_nxt = rnd - 4'd2;
                end
`else
                if (rnd == 4'd0) begin
                    out_nxt   = r0;
                    state_nxt = DONE;
                end else begin
                    st_nxt  = r0;
                    rnd_nxt = rnd - 4'd1;
                end
`endif
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
